// File: rtl/gf_pkg.sv
// ---------------------------------------------------------------------------
// gf_pkg
// Shared definitions for the iterative GF(2^WIDTH) multiplier:
//   - FSM state encoding used by gf_mult_iter
//   - AES reduction polynomial constant (x^8 term implicit)
//   - legal field width limits and a helper to test them
// No ports (package).
// ---------------------------------------------------------------------------
package gf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } gf_state_e;

    localparam logic [7:0]  GF_POLY_AES  = 8'h1B;
    localparam int unsigned GF_WIDTH_MIN = 2;
    localparam int unsigned GF_WIDTH_MAX = 16;

    function automatic bit gf_width_ok(input int unsigned w);
        return (w >= GF_WIDTH_MIN) && (w <= GF_WIDTH_MAX);
    endfunction

endpackage

// File: rtl/gf_xtime_p.sv
// ---------------------------------------------------------------------------
// gf_xtime_p
// Purely combinational multiply-by-x in GF(2^WIDTH): shift left one bit and
// fold the dropped x^WIDTH term back in with the reduction polynomial.
// Ports:
//   a_i     [WIDTH-1:0]  field element
//   a_xt_o  [WIDTH-1:0]  a_i * x  mod (x^WIDTH + POLY)
// ---------------------------------------------------------------------------
module gf_xtime_p
    import gf_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(GF_POLY_AES)
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] a_xt_o
);

    assign a_xt_o = {a_i[WIDTH-2:0], 1'b0} ^ (a_i[WIDTH-1] ? POLY : '0);

endmodule

// File: rtl/gf_mult_iter.sv
// ---------------------------------------------------------------------------
// gf_mult_iter
// Bit-serial GF(2^WIDTH) multiplier. One operand pair is accepted in IDLE,
// the product is built over exactly WIDTH RUN cycles (multiplier consumed
// LSB first, multiplicand repeatedly multiplied by x), then held in DONE
// until the consumer takes it.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for operands, in_ready high
//   RUN   | one shift-and-xor step per cycle, WIDTH steps total
//   DONE  | product valid on out_p, waiting for out_ready
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   operand pair valid
//   in_ready_o   block can accept operands (IDLE)
//   in_a_i       multiplicand
//   in_b_i       multiplier
//   out_valid_o  out_p_o holds a finished product (DONE)
//   out_ready_i  consumer accepts out_p_o
//   out_p_o      product register, visible in every state
//   busy_o       operation in progress (RUN or DONE)
// ---------------------------------------------------------------------------
module gf_mult_iter
    import gf_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(GF_POLY_AES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_p_o,
    output logic             busy_o
);

    localparam int unsigned      CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    if ((WIDTH < GF_WIDTH_MIN) || (WIDTH > GF_WIDTH_MAX)) begin : g_width_check
        $error("gf_mult_iter: WIDTH %0d outside %0d..%0d", WIDTH, GF_WIDTH_MIN, GF_WIDTH_MAX);
    end

    gf_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] a_xt;

    gf_xtime_p #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_xtime (
        .a_i    (a_q),
        .a_xt_o (a_xt)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    a_d     = in_a_i;
                    b_d     = in_b_i;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Carry-less accumulate: add (xor) the current x^i * A term
                // when multiplier bit i is set.
                p_d   = p_q ^ (b_q[0] ? a_q : '0);
                a_d   = a_xt;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                // Fixed WIDTH steps regardless of operand values, so the
                // latency never depends on data.
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flags follow the next state so they are registered alongside it.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign out_p_o     = p_q;

endmodule

// File: tb/tb_gf_mult_iter.sv
// ---------------------------------------------------------------------------
// tb_gf_mult_iter
// Self-checking bench: an 8-bit AES instance and a 4-bit (x^4+x+1) instance
// share stimulus; sel picks which one is driven and observed. Expected
// products are queued when operands are driven and popped on out_valid.
// ---------------------------------------------------------------------------
module tb_gf_mult_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic       sel;
    logic [7:0] in_a, in_b;

    logic       ir8, ov8, busy8;
    logic [7:0] p8;
    logic       ir4, ov4, busy4;
    logic [3:0] p4;

    gf_mult_iter dut8 (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid & ~sel),
        .in_ready_o  (ir8),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .out_valid_o (ov8),
        .out_ready_i (out_ready),
        .out_p_o     (p8),
        .busy_o      (busy8)
    );

    gf_mult_iter #(.WIDTH(4), .POLY(4'h3)) dut4 (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid & sel),
        .in_ready_o  (ir4),
        .in_a_i      (in_a[3:0]),
        .in_b_i      (in_b[3:0]),
        .out_valid_o (ov4),
        .out_ready_i (out_ready),
        .out_p_o     (p4),
        .busy_o      (busy4)
    );

    logic        ir_m, ov_m, busy_m;
    logic [15:0] p_m;
    assign ir_m   = sel ? ir4   : ir8;
    assign ov_m   = sel ? ov4   : ov8;
    assign busy_m = sel ? busy4 : busy8;
    assign p_m    = sel ? {12'd0, p4} : {8'd0, p8};

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: full carry-less product, then long-division reduction from
    // the top bit down by the complete polynomial x^w + poly.
    function automatic logic [15:0] gf_ref(input logic [15:0] a, input logic [15:0] b,
                                           input int w, input logic [15:0] poly);
        logic [31:0] prod;
        logic [31:0] full;
        prod = 32'd0;
        for (int i = 0; i < w; i++)
            if (b[i]) prod = prod ^ (32'(a) << i);
        full = (32'd1 << w) | 32'(poly);
        for (int i = 2 * w - 2; i >= w; i--)
            if (prod[i]) prod = prod ^ (full << (i - w));
        return prod[15:0];
    endfunction

    // Called at a negedge with the selected DUT idle. Returns at a negedge
    // with the DUT idle again.
    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                      input int stall, input bit noise);
        int          w;
        int          n;
        logic [15:0] e;
        w = sel ? 4 : 8;
        chk("ready_before", ir_m, 1'b1);
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        chk("accepted", {ir_m, ov_m, busy_m}, 3'b001);
        if (noise) begin
            in_a = ~a;
            in_b = 8'h5A;
        end else begin
            in_valid = 1'b0;
        end
        n = 0;
        while (!ov_m && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, w);
        e = exp_q.pop_front();
        if (!ov_m) begin
            rst = 1'b1;
            in_valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        chk("product", p_m, e);
        if (stall > 0) begin
            out_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk("hold_valid", {ov_m, ir_m, busy_m}, 3'b101);
                chk("hold_p", p_m, e);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("idle_after_hs", {ir_m, ov_m, busy_m}, 3'b100);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int          pulses;
        logic [7:0]  ra, rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sel       = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst8", {ir8, ov8, busy8, p8}, {3'b100, 8'h00});
        chk("rst4", {ir4, ov4, busy4, p4}, {3'b100, 4'h0});
        rst = 1'b0;
        @(negedge clk);

        op(8'h57, 8'h83, 16'hC1, 0, 0);
        op(8'h57, 8'h13, 16'hFE, 0, 0);
        op(8'h80, 8'h02, 16'h1B, 0, 0);
        op(8'hFF, 8'h00, 16'h00, 0, 0);
        op(8'hA5, 8'h01, 16'hA5, 0, 0);
        op(8'h57, 8'h83, 16'hC1, 5, 1);

        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            op(ra, rb, gf_ref({8'd0, ra}, {8'd0, rb}, 8, 16'h1B),
               int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Reset during RUN, on the edge that would perform step 3.
        in_a     = 8'h57;
        in_b     = 8'h83;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_state", {ir_m, ov_m, busy_m}, 3'b100);
        chk("abort_p", p_m, 16'h0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (ov_m) pulses++;
        end
        chk("abort_no_valid", pulses, 0);
        op(8'h57, 8'h83, 16'hC1, 0, 0);

        sel = 1'b1;
        @(negedge clk);
        op(8'h08, 8'h02, 16'h3, 0, 0);
        op(8'h09, 8'h09, 16'hD, 2, 1);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                op(8'(a), 8'(b), gf_ref(16'(a), 16'(b), 4, 16'h3), 0, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf_mult_iter.md
GF_MULT_ITER -- requirements
Module: gf_mult_iter

Interface
REQ-001 Parameter WIDTH, default 8, field element width in bits; legal range 2..16.
REQ-002 Parameter POLY, default 8'h1B (AES), reduction polynomial low WIDTH bits; the x^WIDTH term is implicit.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand pair on in_a/in_b is valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 in_a  input  WIDTH  multiplicand.
REQ-008 in_b  input  WIDTH  multiplier.
REQ-009 out_valid  output  1  out_p holds a finished product.
REQ-010 out_ready  input  1  consumer accepts out_p.
REQ-011 out_p  output  WIDTH  product in_a*in_b in GF(2^WIDTH) mod POLY.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 FSM states: IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state!=IDLE).
REQ-014 IDLE: on in_valid & in_ready, the block captures in_a into reg A, in_b into reg B, clears reg P and step counter, and goes to RUN.
REQ-015 RUN, one step per cycle, B consumed LSB-first: P <= P ^ (B[0] ? A : 0); A <= xtime(A); B <= B >> 1; counter increments.
REQ-016 xtime(A) = {A[WIDTH-2:0],1'b0} ^ (A[WIDTH-1] ? POLY : 0).
REQ-017 RUN always lasts exactly WIDTH cycles; no early exit for zero operands; after step WIDTH-1 the next state is DONE.
REQ-018 Latency: out_valid rises exactly WIDTH cycles after the acceptance edge; at most one operation in flight.
REQ-019 DONE: out_p = P, held stable with out_valid until out_valid & out_ready; on that edge go to IDLE.
REQ-020 in_valid is ignored outside IDLE; no operand queueing; a new pair is accepted no earlier than the cycle after the output handshake.
REQ-021 out_p is don't-care-free: it shows reg P in all states and is 0 after reset.
REQ-022 Counter width is clog2(WIDTH)+1; it does not wrap within an operation.
REQ-023 Arithmetic is carry-less (XOR only); no integer adders in the datapath.

Reset
REQ-024 rst high on a rising edge forces state IDLE and A, B, P and counter to 0, overriding any handshake in the same cycle.
REQ-025 After reset: in_ready=1, out_valid=0, busy=0, out_p=0.
REQ-026 Reset during RUN or DONE aborts the operation; the partial or unread product is discarded and no out_valid pulse follows.

Structure
REQ-027 Shared package gf_pkg holds the state encoding (IDLE=0, RUN=1, DONE=2), the constant GF_POLY_AES=8'h1B, and the WIDTH legality limits.
REQ-028 One sub-module, gf_xtime_p (parameters WIDTH and POLY), is purely combinational and implements REQ-016; gf_mult_iter instantiates it once on reg A.
REQ-029 An elaboration-time check rejects WIDTH outside 2..16.

Verification
REQ-030 Defaults, a=8'h57, b=8'h83, out_ready=1 -> out_p=8'hC1, out_valid exactly 8 cycles after acceptance (FIPS-197).
REQ-031 Defaults: 8'h57*8'h13 -> 8'hFE; 8'h80*8'h02 -> 8'h1B; 8'hFF*8'h00 -> 8'h00; 8'hA5*8'h01 -> 8'hA5.
REQ-032 Backpressure: out_ready=0 for 5 cycles after DONE -> out_p and out_valid stable and in_ready=0 throughout; new in_valid ignored; IDLE the cycle after out_ready=1.
REQ-033 Reset asserted at RUN step 3 -> next cycle in_ready=1, out_valid=0, out_p=0; a fresh 8'h57*8'h83 then yields 8'hC1.
REQ-034 WIDTH=4, POLY=4'h3: 4'h8*4'h2 -> 4'h3 and 4'h9*4'h9 -> 4'hD, latency 4 cycles; exhaustive 4-bit sweep against a software model.
